// File: rtl/zrle_pkg.sv
// Shared definitions for the zero-run-length encoder and its read-path decoder.
package zrle_pkg;

  localparam int ZRLE_NUM_WIDTH = 16;
  localparam int ZRLE_RUN_WIDTH = 8;
  localparam int RUN_MAX        = 2**ZRLE_RUN_WIDTH - 1;

  typedef struct packed {
    logic [ZRLE_RUN_WIDTH-1:0] run;
    logic [ZRLE_NUM_WIDTH-1:0] value;
  } zrle_token_t;

  // Negative words are non-zero here; only an all-zero word extends a run.
  function automatic logic is_zero(input logic [ZRLE_NUM_WIDTH-1:0] word);
    return (word == '0);
  endfunction

endpackage

// File: rtl/zrle_encoder.sv
// Folds runs of zero activations into {run, value} tokens ahead of writeback.
// One output register; the run counter doubles as the IDLE/RUN state.
module zrle_encoder
  import zrle_pkg::*;
#(
  parameter int NUM_WIDTH = ZRLE_NUM_WIDTH,
  parameter int RUN_WIDTH = ZRLE_RUN_WIDTH
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           bypass,
  input  logic                           up_valid,
  output logic                           up_ready,
  input  logic [NUM_WIDTH-1:0]           up_data,
  input  logic                           up_last,
  output logic                           dn_valid,
  input  logic                           dn_ready,
  output logic [RUN_WIDTH+NUM_WIDTH-1:0] dn_data,
  output logic                           dn_last
);

  localparam logic [RUN_WIDTH-1:0] RUN_LIMIT = '1;

  logic                           accept;
  logic                           word_zero;
  logic [RUN_WIDTH-1:0]           run_cnt;
  logic [RUN_WIDTH-1:0]           run_cnt_nxt;
  logic                           dn_valid_nxt;
  logic [RUN_WIDTH+NUM_WIDTH-1:0] dn_data_nxt;
  logic                           dn_last_nxt;

  assign up_ready  = !dn_valid || dn_ready;
  assign accept    = up_valid && up_ready;
  assign word_zero = (up_data == '0);

  // A token that is not retired stays put; a retired one is replaced only if the accepted word emits.
  always_comb begin
    run_cnt_nxt  = run_cnt;
    dn_valid_nxt = dn_valid && !dn_ready;
    dn_data_nxt  = dn_data;
    dn_last_nxt  = dn_last;
    if (accept) begin
      if (bypass) begin
        dn_valid_nxt = 1'b1;
        dn_data_nxt  = {{RUN_WIDTH{1'b0}}, up_data};
        dn_last_nxt  = up_last;
      end else if (up_last) begin
        dn_valid_nxt = 1'b1;
        dn_data_nxt  = {run_cnt, up_data};
        dn_last_nxt  = 1'b1;
        run_cnt_nxt  = '0;
      end else if (!word_zero) begin
        dn_valid_nxt = 1'b1;
        dn_data_nxt  = {run_cnt, up_data};
        dn_last_nxt  = 1'b0;
        run_cnt_nxt  = '0;
      end else if (run_cnt == RUN_LIMIT) begin
        dn_valid_nxt = 1'b1;
        dn_data_nxt  = {RUN_LIMIT, {NUM_WIDTH{1'b0}}};
        dn_last_nxt  = 1'b0;
        run_cnt_nxt  = '0;
      end else begin
        run_cnt_nxt  = run_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      run_cnt  <= '0;
      dn_valid <= 1'b0;
      dn_data  <= '0;
      dn_last  <= 1'b0;
    end else begin
      run_cnt  <= run_cnt_nxt;
      dn_valid <= dn_valid_nxt;
      dn_data  <= dn_data_nxt;
      dn_last  <= dn_last_nxt;
    end
  end

endmodule

// File: tb/tb_zrle_encoder.sv
// Scoreboard bench for zrle_encoder: a reference model predicts tokens, a monitor retires them
// and re-expands each row to confirm the word count survives encoding.
module tb_zrle_encoder;
  import zrle_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        bypass;
  logic        up_valid;
  logic        up_ready;
  logic [15:0] up_data;
  logic        up_last;
  logic        dn_valid;
  logic        dn_ready;
  logic [23:0] dn_data;
  logic        dn_last;

  int n_compared = 0;
  int n_mismatched = 0;
  int bp_mode = 0;
  int m_run = 0;
  int row_words = 0;
  int row_sum = 0;
  logic [24:0] exp_q[$];
  int row_q[$];

  zrle_encoder dut (
    .clk     (clk),
    .rst     (rst),
    .bypass  (bypass),
    .up_valid(up_valid),
    .up_ready(up_ready),
    .up_data (up_data),
    .up_last (up_last),
    .dn_valid(dn_valid),
    .dn_ready(dn_ready),
    .dn_data (dn_data),
    .dn_last (dn_last)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_compared++;
    if (observed !== expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s observed=%0h expected=%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  // Drives one word, waits for its handshake, predicts the token and checks the one-cycle latency.
  task automatic applyStimulus(input logic [15:0] d, input logic l, input logic b);
    int          waited = 0;
    logic        fired = 1'b0;
    logic        retire = 1'b0;
    logic        emit;
    logic        tl;
    zrle_token_t tok;
    @(negedge clk);
    up_valid = 1'b1;
    up_data  = d;
    up_last  = l;
    bypass   = b;
    while (!fired) begin
      #4;
      if (up_ready) begin
        fired  = 1'b1;
        retire = dn_valid && dn_ready;
      end else begin
        waited++;
        if (waited > 500) begin
          checkOutput("accept_timeout", waited, 500);
          up_valid = 1'b0;
          return;
        end
        @(negedge clk);
      end
    end
    emit = 1'b1;
    tl   = 1'b0;
    tok  = '0;
    if (b) begin
      tok.value = d;
      tl        = l;
    end else if (l) begin
      tok.run   = 8'(m_run);
      tok.value = d;
      tl        = 1'b1;
      m_run     = 0;
    end else if (d != 16'd0) begin
      tok.run   = 8'(m_run);
      tok.value = d;
      m_run     = 0;
    end else if (m_run == RUN_MAX) begin
      tok.run   = 8'(RUN_MAX);
      m_run     = 0;
    end else begin
      emit  = 1'b0;
      m_run = m_run + 1;
    end
    if (emit) exp_q.push_back({tl, tok});
    row_words++;
    if (l) begin
      row_q.push_back(row_words);
      row_words = 0;
    end
    @(posedge clk);
    #1;
    up_valid = 1'b0;
    if (emit) begin
      checkOutput("latency_valid", 32'(dn_valid), 32'd1);
      checkOutput("latency_token", {7'd0, dn_last, dn_data}, {7'd0, tl, tok});
    end else if (retire) begin
      checkOutput("absorbed_no_token", 32'(dn_valid), 32'd0);
    end
  endtask

  task automatic waitDrain();
    int n = 0;
    while (exp_q.size() != 0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    checkOutput("drain", exp_q.size(), 0);
  endtask

  task automatic resetDut(input int cycles);
    @(negedge clk);
    rst = 1'b1;
    exp_q.delete();
    row_q.delete();
    m_run = 0;
    row_words = 0;
    row_sum = 0;
    repeat (cycles) @(negedge clk);
    #2;
    checkOutput("rst_dn_valid", 32'(dn_valid), 32'd0);
    checkOutput("rst_dn_data", 32'(dn_data), 32'd0);
    checkOutput("rst_dn_last", 32'(dn_last), 32'd0);
    rst = 1'b0;
    #1;
    checkOutput("rst_up_ready", 32'(up_ready), 32'd1);
  endtask

  // Backpressure source: always ready, held off, or random.
  initial begin
    dn_ready = 1'b1;
    forever begin
      @(negedge clk);
      case (bp_mode)
        0:       dn_ready = 1'b1;
        1:       dn_ready = 1'b0;
        default: dn_ready = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  // Monitor: retire tokens against the scoreboard and re-expand rows.
  initial begin
    logic [24:0] e;
    forever begin
      @(negedge clk);
      #4;
      if (!rst && dn_valid && dn_ready) begin
        if (exp_q.size() == 0) begin
          checkOutput("unexpected_token", exp_q.size(), 1);
        end else begin
          e = exp_q.pop_front();
          checkOutput("token", {7'd0, dn_last, dn_data}, {7'd0, e});
        end
        row_sum += int'(dn_data[23:16]) + 1;
        if (dn_last) begin
          if (row_q.size() == 0) checkOutput("orphan_last", row_q.size(), 1);
          else checkOutput("row_words", row_sum, row_q.pop_front());
          row_sum = 0;
        end
      end
    end
  end

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog expired at %0t", $time);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int   total;
    int   len;
    logic brow;
    int   zero_pct;
    logic [15:0] d;
    rst = 1'b1;
    bypass = 1'b0;
    up_valid = 1'b0;
    up_data = '0;
    up_last = 1'b0;
    resetDut(3);

    // Reset in the middle of a run discards the partial run.
    applyStimulus(16'd0, 1'b0, 1'b0);
    applyStimulus(16'd0, 1'b0, 1'b0);
    applyStimulus(16'd0, 1'b0, 1'b0);
    resetDut(1);
    applyStimulus(16'd5, 1'b1, 1'b0);
    waitDrain();

    applyStimulus(16'd5, 1'b0, 1'b0);
    applyStimulus(16'd0, 1'b0, 1'b0);
    applyStimulus(16'd0, 1'b0, 1'b0);
    applyStimulus(16'd0, 1'b0, 1'b0);
    applyStimulus(16'd7, 1'b0, 1'b0);
    applyStimulus(16'd9, 1'b1, 1'b0);
    waitDrain();

    for (int i = 0; i < 300; i++) applyStimulus(16'd0, (i == 299), 1'b0);
    waitDrain();

    applyStimulus(16'd0, 1'b0, 1'b1);
    applyStimulus(16'd0, 1'b0, 1'b1);
    applyStimulus(16'd4, 1'b0, 1'b1);
    applyStimulus(16'd0, 1'b1, 1'b1);
    waitDrain();

    // Held backpressure: token {2,6} must sit still and block upstream.
    applyStimulus(16'd0, 1'b0, 1'b0);
    applyStimulus(16'd0, 1'b0, 1'b0);
    bp_mode = 1;
    applyStimulus(16'd6, 1'b0, 1'b0);
    fork
      applyStimulus(16'd8, 1'b1, 1'b0);
      begin
        repeat (4) begin
          @(negedge clk);
          #4;
          checkOutput("hold_valid", 32'(dn_valid), 32'd1);
          checkOutput("hold_data", {8'd0, dn_data}, {8'd0, 8'd2, 16'd6});
          checkOutput("hold_up_ready", 32'(up_ready), 32'd0);
        end
        bp_mode = 0;
      end
    join
    waitDrain();

    // Random sparse rows under random backpressure.
    bp_mode = 2;
    total = 0;
    while (total < 10000) begin
      len      = $urandom_range(1, 400);
      brow     = ($urandom_range(0, 7) == 0);
      zero_pct = ($urandom_range(0, 4) == 0) ? 98 : 70;
      for (int i = 0; i < len; i++) begin
        d = ($urandom_range(0, 99) < zero_pct) ? 16'd0 : 16'($urandom_range(1, 65535));
        applyStimulus(d, (i == len - 1), brow);
      end
      total += len;
    end
    waitDrain();
    checkOutput("rows_pending", row_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
